// File: rtl/ddr_frame_arbiter.sv
// Round-robin scheduler sharing one DDR command engine between the capture
// write stream and the display read stream, with triple-buffered frame indices.
module ddr_frame_arbiter #(
  parameter int                         CTRL_ADDR_WIDTH = 28,
  parameter logic [CTRL_ADDR_WIDTH-1:0] BASE_ADDR       = '0,
  parameter logic [CTRL_ADDR_WIDTH-1:0] FRAME_STRIDE    = CTRL_ADDR_WIDTH'(28'h0200000),
  parameter int                         FRAME_WORDS     = 115200,
  parameter int                         BURST_WORDS     = 64,
  parameter int                         ADDR_PER_WORD   = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wr_frame_start,
  input  logic [16:0]                wr_fifo_level,
  input  logic                       rd_frame_start,
  input  logic [16:0]                rd_fifo_space,
  output logic                       wr_cmd_en,
  output logic [CTRL_ADDR_WIDTH-1:0] wr_cmd_addr,
  output logic [31:0]                wr_cmd_len,
  input  logic                       wr_cmd_ready,
  input  logic                       wr_cmd_done,
  output logic                       rd_cmd_en,
  output logic [CTRL_ADDR_WIDTH-1:0] rd_cmd_addr,
  output logic [31:0]                rd_cmd_len,
  input  logic                       rd_cmd_ready,
  input  logic                       rd_cmd_done,
  output logic [1:0]                 wr_frame_idx,
  output logic [1:0]                 rd_frame_idx,
  output logic                       frame_drop
);

  localparam logic [31:0] FW  = 32'(FRAME_WORDS);
  localparam logic [31:0] BW  = 32'(BURST_WORDS);
  localparam logic [31:0] APW = 32'(ADDR_PER_WORD);

  typedef enum logic [2:0] {IDLE, WR_REQ, WR_WAIT, RD_REQ, RD_WAIT} state_t;

  state_t state_reg, state_next;

  logic [1:0]                 wr_idx_reg, rd_idx_reg, done_idx_reg;
  logic                       done_valid_reg, wr_active_reg, rd_active_reg;
  logic [31:0]                wr_offset_reg, rd_offset_reg;
  logic                       rr_last_rd_reg;
  logic                       wr_pend_reg, rd_pend_reg;
  logic [CTRL_ADDR_WIDTH-1:0] wr_cmd_addr_reg, rd_cmd_addr_reg;
  logic [31:0]                wr_cmd_len_reg, rd_cmd_len_reg;
  logic                       frame_drop_reg;

  logic [31:0] wr_nxt_len, rd_nxt_len;
  logic        wr_elig, rd_elig;
  logic        grant_wr, grant_rd;
  logic        consume, rd_apply;
  logic [1:0]  rd_idx_eff, wr_new_idx;
  logic        rd_active_eff;

  function automatic logic [31:0] burst_len(input logic [31:0] off);
    logic [31:0] rem;
    rem = FW - off;
    return (rem < BW) ? rem : BW;
  endfunction

  function automatic logic [CTRL_ADDR_WIDTH-1:0] burst_addr(input logic [1:0] idx,
                                                            input logic [31:0] off);
    return BASE_ADDR + FRAME_STRIDE * CTRL_ADDR_WIDTH'(idx) + CTRL_ADDR_WIDTH'(off * APW);
  endfunction

  // Lowest buffer not protected by the reader or by the newest finished frame.
  // The reader's buffer is only protected once a read has actually started.
  function automatic logic [1:0] pick_idx(input logic [1:0] ri, input logic rex,
                                          input logic [1:0] di, input logic dex);
    logic [1:0] r;
    r = 2'd0;
    for (int i = 2; i >= 0; i--) begin
      if (!(rex && ri == 2'(i)) && !(dex && di == 2'(i))) r = 2'(i);
    end
    return r;
  endfunction

  always_comb begin
    wr_nxt_len = burst_len(wr_offset_reg);
    rd_nxt_len = burst_len(rd_offset_reg);
    wr_elig    = wr_active_reg && (wr_offset_reg < FW) && ({15'd0, wr_fifo_level} >= wr_nxt_len);
    rd_elig    = rd_active_reg && (rd_offset_reg < FW) && ({15'd0, rd_fifo_space} >= rd_nxt_len);
  end

  // Read start is applied before write start so index selection sees the new reader.
  always_comb begin
    consume       = (state_reg == IDLE) && (wr_pend_reg || rd_pend_reg);
    rd_apply      = consume && rd_pend_reg && done_valid_reg;
    rd_idx_eff    = rd_apply ? done_idx_reg : rd_idx_reg;
    rd_active_eff = rd_apply || rd_active_reg;
    wr_new_idx    = pick_idx(rd_idx_eff, rd_active_eff, done_idx_reg, done_valid_reg);
  end

  always_ff @(posedge clk) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    grant_wr   = 1'b0;
    grant_rd   = 1'b0;
    case (state_reg)
      IDLE: begin
        if (!(wr_pend_reg || rd_pend_reg)) begin
          if (wr_elig && rd_elig) begin
            grant_wr = rr_last_rd_reg;
            grant_rd = !rr_last_rd_reg;
          end else begin
            grant_wr = wr_elig;
            grant_rd = rd_elig;
          end
          if (grant_wr)      state_next = WR_REQ;
          else if (grant_rd) state_next = RD_REQ;
        end
      end
      WR_REQ:  if (wr_cmd_ready) state_next = WR_WAIT;
      WR_WAIT: if (wr_cmd_done)  state_next = IDLE;
      RD_REQ:  if (rd_cmd_ready) state_next = RD_WAIT;
      RD_WAIT: if (rd_cmd_done)  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    wr_cmd_en = 1'b0;
    rd_cmd_en = 1'b0;
    case (state_reg)
      WR_REQ:  wr_cmd_en = wr_cmd_ready;
      RD_REQ:  rd_cmd_en = rd_cmd_ready;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_idx_reg      <= 2'd0;
      rd_idx_reg      <= 2'd0;
      done_idx_reg    <= 2'd0;
      done_valid_reg  <= 1'b0;
      wr_active_reg   <= 1'b0;
      rd_active_reg   <= 1'b0;
      wr_offset_reg   <= 32'd0;
      rd_offset_reg   <= 32'd0;
      rr_last_rd_reg  <= 1'b1;
      wr_pend_reg     <= 1'b0;
      rd_pend_reg     <= 1'b0;
      wr_cmd_addr_reg <= '0;
      rd_cmd_addr_reg <= '0;
      wr_cmd_len_reg  <= 32'd0;
      rd_cmd_len_reg  <= 32'd0;
      frame_drop_reg  <= 1'b0;
    end else begin
      frame_drop_reg <= 1'b0;
      // A pulse arriving in the consume cycle stays pending for the next one.
      wr_pend_reg    <= wr_frame_start || (wr_pend_reg && !consume);
      rd_pend_reg    <= rd_frame_start || (rd_pend_reg && !consume);

      if (rd_apply) begin
        rd_idx_reg    <= done_idx_reg;
        rd_offset_reg <= 32'd0;
        rd_active_reg <= 1'b1;
      end
      if (consume && wr_pend_reg) begin
        frame_drop_reg <= wr_active_reg && (wr_offset_reg < FW);
        wr_idx_reg     <= wr_new_idx;
        wr_offset_reg  <= 32'd0;
        wr_active_reg  <= 1'b1;
      end

      if (grant_wr) begin
        wr_cmd_addr_reg <= burst_addr(wr_idx_reg, wr_offset_reg);
        wr_cmd_len_reg  <= wr_nxt_len;
        rr_last_rd_reg  <= 1'b0;
      end
      if (grant_rd) begin
        rd_cmd_addr_reg <= burst_addr(rd_idx_reg, rd_offset_reg);
        rd_cmd_len_reg  <= rd_nxt_len;
        rr_last_rd_reg  <= 1'b1;
      end

      if (state_reg == WR_WAIT && wr_cmd_done) begin
        wr_offset_reg <= wr_offset_reg + wr_cmd_len_reg;
        if (wr_offset_reg + wr_cmd_len_reg >= FW) begin
          done_idx_reg   <= wr_idx_reg;
          done_valid_reg <= 1'b1;
          wr_active_reg  <= 1'b0;
        end
      end
      if (state_reg == RD_WAIT && rd_cmd_done) begin
        rd_offset_reg <= rd_offset_reg + rd_cmd_len_reg;
      end
    end
  end

  assign wr_cmd_addr  = wr_cmd_addr_reg;
  assign wr_cmd_len   = wr_cmd_len_reg;
  assign rd_cmd_addr  = rd_cmd_addr_reg;
  assign rd_cmd_len   = rd_cmd_len_reg;
  assign wr_frame_idx = wr_idx_reg;
  assign rd_frame_idx = rd_idx_reg;
  assign frame_drop   = frame_drop_reg;

endmodule

// File: tb/tb_ddr_frame_arbiter.sv
// Directed bench for ddr_frame_arbiter with a 100-word frame (bursts of 64 then 36).
module tb_ddr_frame_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        wr_frame_start, rd_frame_start;
  logic [16:0] wr_fifo_level, rd_fifo_space;
  logic        wr_cmd_en, rd_cmd_en;
  logic [27:0] wr_cmd_addr, rd_cmd_addr;
  logic [31:0] wr_cmd_len, rd_cmd_len;
  logic        wr_cmd_ready, wr_cmd_done, rd_cmd_ready, rd_cmd_done;
  logic [1:0]  wr_frame_idx, rd_frame_idx;
  logic        frame_drop;

  int total = 0;
  int bad   = 0;
  int cnt;

  always #5 clk = ~clk;

  ddr_frame_arbiter #(
    .CTRL_ADDR_WIDTH(28),
    .BASE_ADDR      (28'h0),
    .FRAME_STRIDE   (28'h0200000),
    .FRAME_WORDS    (100),
    .BURST_WORDS    (64),
    .ADDR_PER_WORD  (8)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .wr_frame_start(wr_frame_start),
    .wr_fifo_level (wr_fifo_level),
    .rd_frame_start(rd_frame_start),
    .rd_fifo_space (rd_fifo_space),
    .wr_cmd_en     (wr_cmd_en),
    .wr_cmd_addr   (wr_cmd_addr),
    .wr_cmd_len    (wr_cmd_len),
    .wr_cmd_ready  (wr_cmd_ready),
    .wr_cmd_done   (wr_cmd_done),
    .rd_cmd_en     (rd_cmd_en),
    .rd_cmd_addr   (rd_cmd_addr),
    .rd_cmd_len    (rd_cmd_len),
    .rd_cmd_ready  (rd_cmd_ready),
    .rd_cmd_done   (rd_cmd_done),
    .wr_frame_idx  (wr_frame_idx),
    .rd_frame_idx  (rd_frame_idx),
    .frame_drop    (frame_drop)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
    $display("check %-14s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Waits (bounded) for a command strobe on one channel and checks its fields.
  task automatic wait_en(input bit is_rd, input logic [27:0] eaddr, input logic [31:0] elen,
                         input string tag);
    bit seen = 1'b0;
    for (int n = 0; n < 200 && !seen; n++) begin
      @(negedge clk);
      seen = is_rd ? rd_cmd_en : wr_cmd_en;
    end
    check({tag, "_seen"}, 64'(seen), 64'd1);
    check({tag, "_addr"}, 64'(is_rd ? rd_cmd_addr : wr_cmd_addr), 64'(eaddr));
    check({tag, "_len"},  64'(is_rd ? rd_cmd_len  : wr_cmd_len),  64'(elen));
  endtask

  task automatic give_done(input bit is_rd);
    @(negedge clk);
    if (is_rd) rd_cmd_done = 1'b1; else wr_cmd_done = 1'b1;
    @(negedge clk);
    rd_cmd_done = 1'b0;
    wr_cmd_done = 1'b0;
  endtask

  task automatic cmd(input bit is_rd, input logic [27:0] eaddr, input logic [31:0] elen,
                     input string tag);
    wait_en(is_rd, eaddr, elen, tag);
    give_done(is_rd);
  endtask

  initial begin
    rst = 1'b1;
    wr_frame_start = 1'b0; rd_frame_start = 1'b0;
    wr_fifo_level = '0;    rd_fifo_space = '0;
    wr_cmd_ready = 1'b0;   rd_cmd_ready = 1'b0;
    wr_cmd_done = 1'b0;    rd_cmd_done = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_wr_en",   64'(wr_cmd_en), 64'd0);
    check("rst_rd_en",   64'(rd_cmd_en), 64'd0);
    check("rst_wr_len",  64'(wr_cmd_len), 64'd0);
    check("rst_rd_addr", 64'(rd_cmd_addr), 64'd0);
    check("rst_drop",    64'(frame_drop), 64'd0);
    rst = 1'b0;
    wr_cmd_ready = 1'b1; rd_cmd_ready = 1'b1;
    rd_fifo_space = 17'd100;

    // Read start with no finished frame is ignored.
    rd_frame_start = 1'b1; @(negedge clk); rd_frame_start = 1'b0;
    cnt = 0;
    for (int i = 0; i < 12; i++) begin @(negedge clk); if (rd_cmd_en) cnt++; end
    check("rd_before_frame", 64'(cnt), 64'd0);

    // Frame 0: 64 words, then a 36-word tail gated by FIFO level.
    wr_fifo_level = 17'd64;
    wr_frame_start = 1'b1; @(negedge clk); wr_frame_start = 1'b0;
    cmd(1'b0, 28'h0, 32'd64, "w0a");
    wr_fifo_level = 17'd35;
    cnt = 0;
    for (int i = 0; i < 12; i++) begin @(negedge clk); if (wr_cmd_en) cnt++; end
    check("w_level35_hold", 64'(cnt), 64'd0);
    wr_fifo_level = 17'd36;
    cmd(1'b0, 28'h200, 32'd36, "w0b");

    // Both starts together: reader takes frame 0, writer gets frame 1; last grant was write.
    wr_fifo_level = 17'd100;
    wr_frame_start = 1'b1; rd_frame_start = 1'b1; @(negedge clk);
    wr_frame_start = 1'b0; rd_frame_start = 1'b0;
    wait_en(1'b1, 28'h0, 32'd64, "r0a");
    check("rd_idx_f0", 64'(rd_frame_idx), 64'd0);
    check("wr_idx_f1", 64'(wr_frame_idx), 64'd1);
    give_done(1'b1);
    cmd(1'b0, 28'h0200000, 32'd64, "w1a");
    cmd(1'b1, 28'h0000200, 32'd36, "r0b");
    cmd(1'b0, 28'h0200200, 32'd36, "w1b");

    // Frame 2 write; both starts arrive mid-burst and wait for IDLE.
    rd_fifo_space = 17'd0;
    wr_fifo_level = 17'd64;
    wr_frame_start = 1'b1; @(negedge clk); wr_frame_start = 1'b0;
    wait_en(1'b0, 28'h0400000, 32'd64, "w2a");
    wr_frame_start = 1'b1; rd_frame_start = 1'b1; @(negedge clk);
    wr_frame_start = 1'b0; rd_frame_start = 1'b0;
    wr_fifo_level = 17'd0;
    check("drop_not_early", 64'(frame_drop), 64'd0);
    give_done(1'b0);
    cnt = 0;
    for (int i = 0; i < 8; i++) begin @(negedge clk); if (frame_drop) cnt++; end
    check("drop_count", 64'(cnt), 64'd1);
    check("wr_idx_after_drop", 64'(wr_frame_idx), 64'd0);
    check("rd_idx_f1", 64'(rd_frame_idx), 64'd1);

    // Ready held low: strobe must stay low, then pulse for exactly one cycle.
    wr_cmd_ready = 1'b0;
    wr_fifo_level = 17'd64;
    cnt = 0;
    for (int i = 0; i < 10; i++) begin @(negedge clk); if (wr_cmd_en) cnt++; end
    check("en_while_not_ready", 64'(cnt), 64'd0);
    check("req_len_held", 64'(wr_cmd_len), 64'd64);
    wr_cmd_ready = 1'b1;
    #1;
    check("en_on_ready", 64'(wr_cmd_en), 64'd1);
    @(negedge clk);
    check("en_one_cycle", 64'(wr_cmd_en), 64'd0);

    // Reset in WR_WAIT clears everything; the late done is ignored.
    rst = 1'b1; @(negedge clk);
    check("mid_rst_wr_len",  64'(wr_cmd_len), 64'd0);
    check("mid_rst_rd_idx",  64'(rd_frame_idx), 64'd0);
    check("mid_rst_wr_addr", 64'(wr_cmd_addr), 64'd0);
    check("mid_rst_wr_en",   64'(wr_cmd_en), 64'd0);
    rst = 1'b0;
    give_done(1'b0);
    cnt = 0;
    for (int i = 0; i < 6; i++) begin @(negedge clk); if (wr_cmd_en || frame_drop) cnt++; end
    check("post_rst_quiet", 64'(cnt), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
